// File: rtl/conf_bus_loader_pkg.sv
// Shared definitions for the configuration bus loader: bus format constants,
// FSM state encoding and the bus word marking helper.
package conf_bus_loader_pkg;

  localparam int CONF_BUS_W     = 64;
  localparam int CONF_VALID_BIT = 63;
  localparam logic [CONF_BUS_W-1:0] CONF_IDLE_WORD = 64'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PAY   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Readers only decode words with the valid bit set, so every emitted word carries it.
  function automatic logic [CONF_BUS_W-1:0] mark_word(input logic [CONF_BUS_W-1:0] w);
    logic [CONF_BUS_W-1:0] r;
    r = w;
    r[CONF_VALID_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/conf_bus_pipe.sv
// Fixed-depth register chain that carries the configuration bus out to the
// fabric; every stage resets to the idle word.
module conf_bus_pipe
  import conf_bus_loader_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CONF_BUS_W-1:0] din,
  output logic [CONF_BUS_W-1:0] dout
);

  logic [CONF_BUS_W-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= CONF_IDLE_WORD;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/conf_bus_loader.sv
// Parses the framed host stream (header N, N payloads, ..., header 0) and
// broadcasts marked payload words onto the pipelined configuration bus.
module conf_bus_loader
  import conf_bus_loader_pkg::*;
#(
  parameter int BUS_STAGES = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CONF_BUS_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CONF_BUS_W-1:0] conf_bus_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output state_e                dbg_state
);

  localparam int FLUSH_W = (BUS_STAGES > 1) ? $clog2(BUS_STAGES) : 1;
  localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(BUS_STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [CNT_WIDTH-1:0]  words_q;
  logic [FLUSH_W-1:0]    flush_q;
  logic [CNT_WIDTH-1:0]  hdr_n;
  logic                  hs;
  logic                  emit;
  logic                  start_ok;
  logic [CONF_BUS_W-1:0] pipe_in;

  assign hdr_n = in_data[CNT_WIDTH-1:0];

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are
  // both high; in_ready depends only on the registered state, never on in_valid.
  assign hs   = in_valid && in_ready;
  assign emit = hs && (state_q == ST_PAY);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = (hdr_n == '0) ? ST_FLUSH : ST_PAY;
      end
      ST_PAY: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (remaining_q == CNT_ONE)) state_d = ST_HDR;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (flush_q == FLUSH_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_HDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FLUSH lasts BUS_STAGES cycles so the final payload has drained to the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      words_q     <= '0;
      flush_q     <= '0;
    end else begin
      if (start_ok)                          words_q <= '0;
      else if (emit && (words_q != CNT_MAX)) words_q <= words_q + 1'b1;

      if (hs && (state_q == ST_HDR)) remaining_q <= hdr_n;
      else if (emit)                 remaining_q <= remaining_q - 1'b1;

      if (state_q == ST_FLUSH) flush_q <= flush_q + 1'b1;
      else                     flush_q <= '0;
    end
  end

  assign pipe_in = emit ? mark_word(in_data) : CONF_IDLE_WORD;

  conf_bus_pipe #(
    .STAGES (BUS_STAGES)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (conf_bus_out)
  );

  assign words_sent = words_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/conf_bus_loader.md
Name: conf_bus_loader

Overview:
- Upstream feeder of every swicth/PE configuration control block in the CGRA.
- Accepts a framed stream of 64-bit configuration words from the host-side FIFO over a valid/ready handshake.
- Broadcasts the payload words onto the shared 64-bit configuration bus through a resettable pipeline, and reports busy/done so the top level can hold en_pc_net low while loading.

Parameters:
- BUS_STAGES, 2, number of output register stages on conf_bus_out; used to spread fanout. Legal range is >=1.
- CNT_WIDTH, 32, width of the payload-count field and of the sent-word counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- in_data  input  64  host stream word
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- conf_bus_out  output  64  configuration bus driven to all conf_bus_in ports
- busy  output  1  load in progress (start accepted, done not yet asserted)
- done  output  1  load complete; sticky until the next accepted start or rst
- words_sent  output  CNT_WIDTH  payload words emitted since the last accepted start

Behaviour:
- Stream framing:
  - A header word carries the payload count N in in_data[CNT_WIDTH-1:0]; its other bits are ignored.
  - The header is followed by N payload words.
  - A header with N=0 terminates the configuration.
- Bus word encoding:
  - An emitted word equals the payload word with bit 63 forced to 1.
  - The idle bus value is 64'h0.
  - Readers decode only words with bit 63 = 1.
- FSM states are IDLE, HDR, PAY, FLUSH, DONE.
  - IDLE: waits for start, then goes to HDR. busy=1 from the cycle after start.
  - HDR: in_ready=1. On handshake, N=0 goes to FLUSH; otherwise load remaining=N and go to PAY.
  - PAY: in_ready=1. Each handshake emits one word, decrements remaining and increments words_sent. When remaining reaches 0 on a handshake, go to HDR.
  - FLUSH: in_ready=0. Wait exactly BUS_STAGES cycles so the last word reaches conf_bus_out, then go to DONE.
  - DONE: done=1, busy=0. A start here clears done, clears words_sent and goes to HDR.
- in_ready is 0 in IDLE, FLUSH and DONE. There are no combinational paths from in_valid to in_ready.
- Latency: a payload accepted at edge t appears on conf_bus_out BUS_STAGES cycles after t. Every non-emitting cycle inserts 64'h0 into the pipeline, so bubbles propagate as zeros.
- Start is ignored in HDR, PAY and FLUSH. No state, counter or output changes.
- in_valid=0 in HDR or PAY: the block stalls, the pipeline shifts zeros, and the count is held.
- words_sent saturates at all-ones and does not wrap.
- Reset, including mid-load:
  - State goes to IDLE.
  - Every pipeline stage clears to 64'h0.
  - busy=0, done=0, words_sent=0, in_ready=0.
  - A partial load is discarded; the host must restart it.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package holds:
  - The FSM state encoding (3 bits).
  - CONF_BUS_W=64.
  - CONF_VALID_BIT=63.
  - CONF_IDLE_WORD=64'h0.
- One natural sub-module, conf_bus_pipe: a BUS_STAGES-deep 64-bit register chain with synchronous reset to zero and no enable.
- The FSM, counters and handshake stay in conf_bus_loader.

Test Plan:
- Basic load, BUS_STAGES=2:
  - Stimulus: start; header N=3; payloads 0x1, 0x2, 0x3 back-to-back; header 0.
  - Response: conf_bus_out = 0x8000_0000_0000_0001/…2/…3 on consecutive cycles, 2 cycles after each accept. done rises 2 cycles after the terminating header; words_sent=3.
- Stalls:
  - Stimulus: the same stream with in_valid deasserted for 2 cycles between payloads 1 and 2.
  - Response: two 64'h0 words appear on the bus between the payloads; words_sent=3 at done.
- Multiple frames:
  - Stimulus: headers N=1 and N=2, then terminator.
  - Response: 3 words are emitted in order, in_ready drops only in FLUSH, and busy stays high until done.
- Start while busy:
  - Stimulus: pulse start during PAY.
  - Response: no effect; words_sent continues and done occurs normally.
- Restart:
  - Stimulus: start from DONE, then header 0.
  - Response: done clears the next cycle, words_sent=0, and done re-asserts after BUS_STAGES cycles.
- Reset mid-load:
  - Stimulus: assert rst after 1 of 3 payloads.
  - Response: next cycle conf_bus_out=0 in all stages, state IDLE, in_ready=0, busy=0, done=0.
